// File: rtl/regfile_writeback_if.sv
// Result-producer and register-file write-port bundle for regfile_writeback.
// Producers drive alu_* and ld_*; the writeback block drives the write port, backpressure and status.
interface regfile_writeback_if #(
  parameter int Dbits = 32,
  parameter int Nloc  = 32,
  parameter int Depth = 4
);
  localparam int AW = $clog2(Nloc);
  localparam int CW = $clog2(Depth) + 1;

  logic             alu_valid;
  logic [AW-1:0]    alu_addr;
  logic [Dbits-1:0] alu_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [AW-1:0]    ld_addr;
  logic [Dbits-1:0] ld_data;
  logic             wr;
  logic [AW-1:0]    WriteAddr;
  logic [Dbits-1:0] WriteData;
  logic [Nloc-1:0]  pending;
  logic [CW-1:0]    qcount;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, wr, WriteAddr, WriteData, pending, qcount
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output ld_ready, wr, WriteAddr, WriteData, pending, qcount
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: the ALU always wins, and load results queue in a
// circular FIFO. Queued loads are killed when a younger ALU write targets the same register.
module regfile_writeback #(
  parameter int Dbits = 32,
  parameter int Nloc  = 32,
  parameter int Depth = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_writeback_if.slave   bus
);
  localparam int AW = $clog2(Nloc);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [Dbits-1:0] data_q [Depth];
  logic [AW-1:0]    addr_q [Depth];
  logic [Depth-1:0] kill_q;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  logic             alu_win, head_valid, head_kill, head_write;
  logic             push, pop, push_kill;
  logic [Nloc-1:0]  pend;

  assign alu_win    = bus.alu_valid && (bus.alu_addr != '0);
  assign head_valid = (count != '0);
  assign head_kill  = kill_q[rd_ptr];
  // A killed head leaves even when the ALU owns the port; it never needs a write slot.
  assign head_write = head_valid && !head_kill && (addr_q[rd_ptr] != '0) && !alu_win;
  assign pop        = head_valid && (head_kill || !alu_win);
  assign bus.ld_ready = (count < CW'(Depth));
  assign push       = bus.ld_valid && bus.ld_ready;
  assign push_kill  = (bus.ld_addr == '0) ||
                      (bus.alu_valid && (bus.alu_addr == bus.ld_addr));

  always_comb begin
    logic [PW-1:0] off;
    pend = '0;
    for (int i = 0; i < Depth; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && !kill_q[i])
        pend[addr_q[i]] = 1'b1;
    end
  end

  assign bus.pending = pend;
  assign bus.qcount  = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      kill_q <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Queued loads are older than the ALU result, so a matching ALU write retires them.
      if (bus.alu_valid) begin
        for (int i = 0; i < Depth; i++)
          if (addr_q[i] == bus.alu_addr)
            kill_q[i] <= 1'b1;
      end
      if (push) begin
        data_q[wr_ptr] <= bus.ld_data;
        addr_q[wr_ptr] <= bus.ld_addr;
        kill_q[wr_ptr] <= push_kill;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr        <= 1'b0;
      bus.WriteAddr <= '0;
      bus.WriteData <= '0;
    end else begin
      bus.wr <= alu_win || head_write;
      if (alu_win) begin
        bus.WriteAddr <= bus.alu_addr;
        bus.WriteData <= bus.alu_data;
      end else if (head_write) begin
        bus.WriteAddr <= addr_q[rd_ptr];
        bus.WriteData <= data_q[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU/load arbitration, FIFO wrap, kill rule, async reset.
module tb_regfile_writeback;
  localparam int Dbits = 32;
  localparam int Nloc  = 32;
  localparam int Depth = 4;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  regfile_writeback_if #(.Dbits(Dbits), .Nloc(Nloc), .Depth(Depth)) bus ();

  regfile_writeback #(.Dbits(Dbits), .Nloc(Nloc), .Depth(Depth)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_data  = d;
  endtask

  task automatic port(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wr"}, 64'(bus.wr), 64'(w));
    chk({tag, ".addr"}, 64'(bus.WriteAddr), 64'(a));
    chk({tag, ".data"}, 64'(bus.WriteData), 64'(d));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    #3;
    port("rst0", 1'b0, 5'd0, 32'h0);
    chk("rst0.qcount", 64'(bus.qcount), 64'd0);
    chk("rst0.ready", 64'(bus.ld_ready), 64'd1);
    chk("rst0.pending", 64'(bus.pending), 64'd0);
    #10;
    reset_n = 1'b1;
    tick();

    // ALU write, then ALU write to r0 is dropped and the port holds
    alu(1'b1, 5'd5, 32'h1234);
    tick();
    port("alu5", 1'b1, 5'd5, 32'h1234);
    alu(1'b1, 5'd0, 32'hFFFF);
    tick();
    port("alu0", 1'b0, 5'd5, 32'h1234);

    // load r7 queued behind three ALU writes to r3
    alu(1'b1, 5'd3, 32'h30);
    ld(1'b1, 5'd7, 32'hAA);
    tick();
    port("ld7.a", 1'b1, 5'd3, 32'h30);
    chk("ld7.a.qcount", 64'(bus.qcount), 64'd1);
    chk("ld7.a.pending", 64'(bus.pending), 64'h80);
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b1, 5'd3, 32'h31);
    tick();
    chk("ld7.b.pending", 64'(bus.pending), 64'h80);
    alu(1'b1, 5'd3, 32'h32);
    tick();
    port("ld7.c", 1'b1, 5'd3, 32'h32);
    chk("ld7.c.pending", 64'(bus.pending), 64'h80);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    port("ld7.w", 1'b1, 5'd7, 32'hAA);
    chk("ld7.w.pending", 64'(bus.pending), 64'd0);
    chk("ld7.w.qcount", 64'(bus.qcount), 64'd0);

    // fill with r1..r4 under ALU traffic; slots 1,2,3,0 exercise pointer wrap
    for (int k = 1; k <= 4; k++) begin
      alu(1'b1, 5'd10, 32'hA0 + 32'(k));
      ld(1'b1, 5'(k), 32'h100 + 32'(k));
      tick();
    end
    chk("fill.qcount", 64'(bus.qcount), 64'd4);
    chk("fill.ready", 64'(bus.ld_ready), 64'd0);
    chk("fill.pending", 64'(bus.pending), 64'h1E);
    port("fill.port", 1'b1, 5'd10, 32'hA4);
    ld(1'b1, 5'd8, 32'h108);
    alu(1'b1, 5'd10, 32'hA5);
    tick();
    chk("full.qcount", 64'(bus.qcount), 64'd4);
    chk("full.ready", 64'(bus.ld_ready), 64'd0);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    port("drain1", 1'b1, 5'd1, 32'h101);
    chk("drain1.qcount", 64'(bus.qcount), 64'd3);
    chk("drain1.pending", 64'(bus.pending), 64'h1C);
    chk("drain1.ready", 64'(bus.ld_ready), 64'd1);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    port("drain2", 1'b1, 5'd2, 32'h102);
    chk("drain2.qcount", 64'(bus.qcount), 64'd3);
    chk("drain2.pending", 64'(bus.pending), 64'h118);
    tick();
    port("drain3", 1'b1, 5'd3, 32'h103);
    chk("drain3.qcount", 64'(bus.qcount), 64'd2);
    tick();
    port("drain4", 1'b1, 5'd4, 32'h104);
    tick();
    port("drain5", 1'b1, 5'd8, 32'h108);
    chk("drain5.qcount", 64'(bus.qcount), 64'd0);
    tick();
    chk("drain.idle.wr", 64'(bus.wr), 64'd0);

    // load r9 killed by a younger ALU write to r9
    alu(1'b1, 5'd11, 32'hB0);
    ld(1'b1, 5'd9, 32'h11);
    tick();
    chk("kill9.a.pending", 64'(bus.pending), 64'h200);
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b1, 5'd9, 32'h22);
    tick();
    port("kill9.b", 1'b1, 5'd9, 32'h22);
    chk("kill9.b.pending", 64'(bus.pending), 64'd0);
    chk("kill9.b.qcount", 64'(bus.qcount), 64'd1);
    alu(1'b0, 5'd0, 32'h0);
    tick();
    port("kill9.c", 1'b0, 5'd9, 32'h22);
    chk("kill9.c.qcount", 64'(bus.qcount), 64'd0);

    // same-cycle load and ALU to r6
    alu(1'b1, 5'd6, 32'h60);
    ld(1'b1, 5'd6, 32'h66);
    tick();
    port("same6.a", 1'b1, 5'd6, 32'h60);
    chk("same6.a.qcount", 64'(bus.qcount), 64'd1);
    chk("same6.a.pending", 64'(bus.pending), 64'd0);
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    tick();
    port("same6.b", 1'b0, 5'd6, 32'h60);
    chk("same6.b.qcount", 64'(bus.qcount), 64'd0);

    // load to r0 is accepted but never written
    ld(1'b1, 5'd0, 32'h77);
    tick();
    ld(1'b0, 5'd0, 32'h0);
    chk("ld0.qcount", 64'(bus.qcount), 64'd1);
    chk("ld0.pending", 64'(bus.pending), 64'd0);
    tick();
    chk("ld0.wr", 64'(bus.wr), 64'd0);
    chk("ld0.qcount2", 64'(bus.qcount), 64'd0);

    // async reset with two live entries
    alu(1'b1, 5'd13, 32'hD0);
    ld(1'b1, 5'd14, 32'hE0);
    tick();
    ld(1'b1, 5'd15, 32'hF0);
    tick();
    chk("pre.qcount", 64'(bus.qcount), 64'd2);
    chk("pre.pending", 64'(bus.pending), 64'hC000);
    chk("pre.wr", 64'(bus.wr), 64'd1);
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    port("arst", 1'b0, 5'd0, 32'h0);
    chk("arst.qcount", 64'(bus.qcount), 64'd0);
    chk("arst.ready", 64'(bus.ld_ready), 64'd1);
    chk("arst.pending", 64'(bus.pending), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post.wr", 64'(bus.wr), 64'd0);
    chk("post.qcount", 64'(bus.qcount), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
